hex8_display_ctrl: RTL and testbench
====================================

Name: hex8_display_ctrl

Overview:
- Eight-digit, time-multiplexed seven-segment display controller with an internal 8 x 4-bit digit register file.
- Digits are loaded one at a time via sel/num/write.
- The block scans the digits continuously, driving one active-low anode at a time plus the active-low hex segment pattern of that digit.
- Sits between user/board control logic and the board's common-anode 8-digit display.

Parameters:
- DIGIT_TICKS, default 100000, clock cycles each digit stays enabled (1 ms at 100 MHz). Legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- write  input  1  write enable; 1 = store num into digit sel on this clock edge.
- sel  input  3  digit index 0..7 to write; digit 0 = rightmost.
- num  input  4  hex value 0x0..0xF to store.
- led  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a} (led[0]=a).
- segment  output  8  digit anodes, active-low, one-hot-low; segment[i]=0 enables digit i.

Behaviour:
- State consists of:
  - digit register file regs[0..7], 4 bits each;
  - tick counter, ceil(log2(DIGIT_TICKS)) bits;
  - scan index idx, 3 bits.
- Reset (reset==0 at rising edge):
  - regs all 0, counter 0, idx 0.
  - Reset dominates write: no write occurs during reset.
- Outputs:
  - Combinational from registered state only (no input-to-output paths).
  - segment = ~(8'b1 << idx).
  - led = decode(regs[idx]).
  - After reset: segment=8'hFE, led=7'h40.
- Write:
  - When reset==1 and write==1, regs[sel] <= num on the rising edge.
  - Other digits are unchanged.
  - Write held high over consecutive cycles rewrites each cycle.
  - write==0 leaves regs unchanged.
  - If sel==idx, led changes immediately after that edge (zero extra latency).
- Scan:
  - When reset==1, the counter increments every cycle.
  - When the counter == DIGIT_TICKS-1, it wraps to 0 and idx increments.
  - idx wraps 7 -> 0.
  - Each digit is enabled for exactly DIGIT_TICKS cycles; full frame = 8*DIGIT_TICKS cycles.
  - Scan runs independently of write; writing does not stall or reset scanning.
  - For DIGIT_TICKS==1, idx advances every cycle.
- Decode table, active-low gfedcba hex:
  - 0:40  1:79  2:24  3:30
  - 4:19  5:12  6:02  7:78
  - 8:00  9:10  A:08  b:03
  - C:46  d:21  E:06  F:0E
- Exactly one segment bit is low at all times, including during and after reset. No blanking interval.
- Reset asserted mid-scan: on the next edge, idx=0 and counter=0 regardless of position. All digit contents are cleared.
- No X propagation: all state has defined reset values. sel and num are sampled only when write==1.

Test Plan:
- Reset/defaults (DIGIT_TICKS=4): hold reset=0 for 3 cycles, then release.
  - Expect segment=FE, led=40 during reset and immediately after.
  - Over 32 cycles, expect every digit to show led=40.
- Load full word: with reset=1, write=1, one cycle each, sel 7..0 with num 2,0,2,2,E,E,1,6; then write=0.
  - Scan one frame and expect (segment -> led):
    - digit 7 (7F) -> 24, digit 6 (BF) -> 40, digit 5 (DF) -> 24, digit 4 (EF) -> 24;
    - digit 3 (F7) -> 06, digit 2 (FB) -> 06, digit 1 (FD) -> 79, digit 0 (FE) -> 02.
- Scan timing (DIGIT_TICKS=4):
  - Each segment value persists exactly 4 cycles.
  - Order is FE, FD, FB, F7, EF, DF, BF, 7F, then FE again (7 -> 0 wrap).
- Full decode sweep: write num=0..F into digit 0 one at a time while idx=0.
  - Expect led to follow the table on the edge after each write.
  - Writes to sel=3 at the same time leave digit 0's led unchanged.
- Reset priority: assert reset=0 together with write=1, sel=5, num=A.
  - Expect regs[5] stays 0 and idx returns to 0.
  - Assert reset mid-frame at idx=6: expect segment=FE on the next cycle.
- Write hold/no-write: write=0 with num/sel toggling for 2 frames -> display unchanged from the previous contents.

Source files
------------

// File: rtl/hex8_display_if.sv
// Bus between board control logic and the 8-digit display controller.
//   write   : store num into digit sel on the next rising clock edge
//   sel     : digit index 0..7, digit 0 is the rightmost
//   num     : hex value to store
//   led     : active-low segment cathodes {g,f,e,d,c,b,a}
//   segment : active-low digit anodes, exactly one bit low
// master : the control side (drives write/sel/num)
// slave  : the display controller (drives led/segment)
interface hex8_display_if;
   logic       write;
   logic [2:0] sel;
   logic [3:0] num;
   logic [6:0] led;
   logic [7:0] segment;

   modport master (output write, output sel, output num,
                   input  led,   input  segment);
   modport slave  (input  write, input  sel, input  num,
                   output led,   output segment);
endinterface

// File: rtl/hex8_display_ctrl.sv
// Eight-digit time-multiplexed seven-segment display controller.
// Holds an 8 x 4-bit digit register file, loaded one digit at a time, and
// scans the digits continuously, enabling each for DIGIT_TICKS cycles.
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-low (0 = reset)
//   bus   : hex8_display_if.slave (write/sel/num in, led/segment out)
// Outputs are decoded from registered state only, so a write to the digit
// currently shown appears on led right after the capturing edge.
module hex8_display_ctrl #(
   parameter int unsigned DIGIT_TICKS = 100000
) (
   input logic           clk,
   input logic           reset,
   hex8_display_if.slave bus
);

   // A single-tick dwell still needs a 1-bit counter that never leaves 0.
   localparam int unsigned     CW   = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam logic [CW-1:0]   LAST = CW'(DIGIT_TICKS - 1);

   logic [3:0]    regs [8];
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [3:0]    cur;
   logic [6:0]    pattern;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
         cnt <= '0;
         idx <= '0;
      end else begin
         if (bus.write) regs[bus.sel] <= bus.num;
         if (cnt == LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign cur = regs[idx];

   always_comb begin
      pattern = 7'h7F;
      case (cur)
         4'h0: pattern = 7'h40;
         4'h1: pattern = 7'h79;
         4'h2: pattern = 7'h24;
         4'h3: pattern = 7'h30;
         4'h4: pattern = 7'h19;
         4'h5: pattern = 7'h12;
         4'h6: pattern = 7'h02;
         4'h7: pattern = 7'h78;
         4'h8: pattern = 7'h00;
         4'h9: pattern = 7'h10;
         4'hA: pattern = 7'h08;
         4'hB: pattern = 7'h03;
         4'hC: pattern = 7'h46;
         4'hD: pattern = 7'h21;
         4'hE: pattern = 7'h06;
         4'hF: pattern = 7'h0E;
         default: pattern = 7'h7F;
      endcase
   end

   assign bus.led     = pattern;
   assign bus.segment = ~(8'b1 << idx);

endmodule

// File: tb/tb_hex8_display_ctrl.sv
module tb_hex8_display_ctrl;

   localparam int TICKS = 4;

   typedef struct {
      int         c;
      int         ph;
      logic [7:0] seg;
      logic [6:0] led;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   base = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];

   logic [3:0] mregs [8];
   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [7:0] scan_order [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [6:0] word_led [8]   = '{7'h02, 7'h79, 7'h06, 7'h06, 7'h24, 7'h24, 7'h40, 7'h24};
   logic [3:0] word_num [8]   = '{4'h2, 4'h0, 4'h2, 4'h2, 4'hE, 4'hE, 4'h1, 4'h6};

   hex8_display_if bus ();

   hex8_display_ctrl #(.DIGIT_TICKS(TICKS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string ph_name(int ph);
      case (ph)
         0: return "reset";
         1: return "defaults";
         2: return "word";
         3: return "hold";
         4: return "decode";
         5: return "other_digit";
         6: return "reset_prio";
         default: return "post_reset";
      endcase
   endfunction

   function automatic int exp_idx(int c);
      return ((c - base) / TICKS) % 8;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(int c, int ph, logic [7:0] seg, logic [6:0] led);
      exp_t e;
      e.c = c; e.ph = ph; e.seg = seg; e.led = led;
      q.push_back(e);
   endtask

   task automatic expect_cycle(int c, int ph);
      int i;
      i = exp_idx(c);
      push(c, ph, scan_order[i], dec[mregs[i]]);
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 200) begin
         step();
         k++;
      end
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: compares every registered expectation on the falling edge of its cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() != 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.c != cyc) begin
               n_fail++;
               $display("FAIL %s: expectation for cycle %0d missed, at cycle %0d",
                        ph_name(e.ph), e.c, cyc);
            end else if (bus.segment !== e.seg || bus.led !== e.led) begin
               n_fail++;
               $display("FAIL %s cyc=%0d: segment=%h led=%h, required segment=%h led=%h",
                        ph_name(e.ph), cyc, bus.segment, bus.led, e.seg, e.led);
            end
         end
      end
   end

   initial begin
      int k;
      bus.write = 1'b0;
      bus.sel   = '0;
      bus.num   = '0;
      reset     = 1'b0;
      for (int i = 0; i < 8; i++) mregs[i] = '0;

      // Reset held for three edges.
      for (int c = 1; c <= 3; c++) push(c, 0, 8'hFE, 7'h40);
      repeat (3) step();
      reset = 1'b1;
      base  = cyc;
      for (int c = cyc + 1; c <= cyc + 32; c++) expect_cycle(c, 1);
      drain();

      // Load the word 2022EE16, digit 7 first.
      for (int j = 0; j < 8; j++) begin
         bus.write = 1'b1;
         bus.sel   = 3'(7 - j);
         bus.num   = word_num[j];
         mregs[7 - j] = word_num[j];
         step();
      end
      bus.write = 1'b0;
      for (int c = cyc; c < cyc + 32; c++) push(c, 2, scan_order[exp_idx(c)], word_led[exp_idx(c)]);
      drain();

      // Inputs toggle with write low for two frames.
      for (int j = 0; j < 64; j++) begin
         bus.sel = 3'($urandom);
         bus.num = 4'($urandom);
         expect_cycle(cyc + 1, 3);
         step();
      end
      drain();

      // Decode sweep on digit 0 while it is displayed; a digit-3 write follows each.
      for (int v = 0; v < 16; v++) begin
         k = 0;
         while (!(exp_idx(cyc + 1) == 0 && exp_idx(cyc + 2) == 0) && k < 40) begin
            step();
            k++;
         end
         if (k >= 40) begin
            n_fail++;
            $display("FAIL decode: digit 0 slot not reached within 40 cycles");
         end
         bus.write = 1'b1;
         bus.sel   = 3'd0;
         bus.num   = 4'(v);
         mregs[0]  = 4'(v);
         push(cyc + 1, 4, 8'hFE, dec[v]);
         step();
         bus.sel   = 3'd3;
         bus.num   = ~4'(v);
         mregs[3]  = ~4'(v);
         push(cyc + 1, 5, 8'hFE, dec[v]);
         step();
         bus.write = 1'b0;
      end
      drain();

      // Reset mid-frame at digit 6, together with a write to digit 5.
      k = 0;
      while (!(exp_idx(cyc) == 6 && exp_idx(cyc + 1) == 6) && k < 40) begin
         step();
         k++;
      end
      if (k >= 40) begin
         n_fail++;
         $display("FAIL reset_prio: digit 6 slot not reached within 40 cycles");
      end
      reset     = 1'b0;
      bus.write = 1'b1;
      bus.sel   = 3'd5;
      bus.num   = 4'hA;
      step();
      base = cyc;
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      push(cyc, 6, 8'hFE, 7'h40);
      reset     = 1'b1;
      bus.write = 1'b0;
      for (int c = cyc + 1; c <= cyc + 32; c++) expect_cycle(c, 7);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
